// File: rtl/adapter_pkg.sv
// Shared types and helpers for the outstanding-transaction arbiter.
package adapter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   // ceil(log2(value)); clogb2(5)=3, clogb2(4)=2, clogb2(1)=0
   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if (v > 0) begin
            r++;
            v = v >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/outstanding_arbiter_rr_pick.sv
// Round-robin pick: first set req bit at or after ptr, wrapping to bit 0.
module rr_pick
   import adapter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] win,
   output logic [ID_W-1:0]    win_id,
   output logic               any
);

   logic            hit;
   logic [ID_W-1:0] hi_id;
   logic [ID_W-1:0] lo_id;

   // Descending scan so the lowest qualifying index is the last one written.
   always_comb begin
      any   = 1'b0;
      hit   = 1'b0;
      hi_id = '0;
      lo_id = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            any   = 1'b1;
            lo_id = ID_W'(i);
            if (ID_W'(i) >= ptr) begin
               hit   = 1'b1;
               hi_id = ID_W'(i);
            end
         end
      end
      win_id = hit ? hi_id : lo_id;
   end

   assign win = any ? (NUM_REQ'(1) << win_id) : '0;

endmodule

// File: rtl/outstanding_arbiter.sv
// Round-robin grant arbiter sharing a pool of MAX_OUT outstanding slots,
// with per-requester tracking so completions can be attributed.
module outstanding_arbiter
   import adapter_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int MAX_OUT = 4,
   localparam int CNT_W   = clogb2(MAX_OUT + 1),
   localparam int ID_W    = (clogb2(NUM_REQ) < 1) ? 1 : clogb2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id,
   output logic               gnt_valid,
   input  logic               gnt_ready,
   input  logic               cpl_valid,
   input  logic [ID_W-1:0]    cpl_id,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty,
   output logic               cpl_err
);

   // Entries at or above NUM_REQ are never granted, so they stay zero
   // and make out-of-range completion ids illegal automatically.
   localparam int PEND_N = 1 << ID_W;

   state_t             state;
   logic [ID_W-1:0]    ptr;
   logic [CNT_W-1:0]   pend [PEND_N];
   logic [NUM_REQ-1:0] win;
   logic [ID_W-1:0]    win_id;
   logic               any;
   logic               hs;
   logic               cpl_ok;
   logic               full_eff;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .win    (win),
      .win_id (win_id),
      .any    (any)
   );

   assign full     = (count == CNT_W'(MAX_OUT));
   assign empty    = (count == '0);
   assign hs       = gnt_valid && gnt_ready;
   assign cpl_ok   = cpl_valid && (pend[cpl_id] != '0) && (count != '0);
   assign full_eff = full && !cpl_ok;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         ptr       <= '0;
         count     <= '0;
         cpl_err   <= 1'b0;
         for (int i = 0; i < PEND_N; i++) begin
            pend[i] <= '0;
         end
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (any && !full_eff) begin
                  gnt       <= win;
                  gnt_id    <= win_id;
                  gnt_valid <= 1'b1;
                  state     <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (gnt_ready) begin
                  gnt       <= '0;
                  gnt_id    <= '0;
                  gnt_valid <= 1'b0;
                  state     <= ST_IDLE;
                  ptr       <= (gnt_id == ID_W'(NUM_REQ - 1)) ?
                               '0 : gnt_id + 1'b1;
               end
            end
         endcase

         if (hs && !cpl_ok) begin
            count <= count + 1'b1;
         end else if (!hs && cpl_ok) begin
            count <= count - 1'b1;
         end

         for (int i = 0; i < PEND_N; i++) begin
            if ((hs && gnt_id == ID_W'(i)) &&
                !(cpl_ok && cpl_id == ID_W'(i))) begin
               pend[i] <= pend[i] + 1'b1;
            end else if ((cpl_ok && cpl_id == ID_W'(i)) &&
                         !(hs && gnt_id == ID_W'(i))) begin
               pend[i] <= pend[i] - 1'b1;
            end
         end

         if (cpl_valid && !cpl_ok) begin
            cpl_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_outstanding_arbiter.sv
// Scoreboard bench for outstanding_arbiter against a queue-based pool model.
module tb_outstanding_arbiter;

   localparam int NUM_REQ = 4;
   localparam int MAX_OUT = 4;
   localparam int ID_W    = 2;
   localparam int CNT_W   = 3;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic [NUM_REQ-1:0] req = '0;
   logic               gnt_ready = 1'b0;
   logic               cpl_valid = 1'b0;
   logic [ID_W-1:0]    cpl_id = '0;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_valid;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               empty;
   logic               cpl_err;

   int n_tests = 0;
   int n_fail  = 0;

   int exp_q[$];
   bit m_offer;
   int m_id;
   int m_ptr;
   int m_count;
   bit m_err;
   int m_pend[NUM_REQ];

   always #5 clk = ~clk;

   outstanding_arbiter #(
      .NUM_REQ (NUM_REQ),
      .MAX_OUT (MAX_OUT)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .gnt_ready (gnt_ready),
      .cpl_valid (cpl_valid),
      .cpl_id    (cpl_id),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .cpl_err   (cpl_err)
   );

   function automatic void chk(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: a pool of slots, per-requester tallies and a
   // rotating priority start; a new offer is predicted when one may begin.
   initial begin
      bit legal;
      bit hs;
      int id;
      forever begin
         @(posedge clk);
         if (!rstn) begin
            m_offer = 0;
            m_id    = 0;
            m_ptr   = 0;
            m_count = 0;
            m_err   = 0;
            for (int i = 0; i < NUM_REQ; i++) m_pend[i] = 0;
            exp_q.delete();
         end else begin
            legal = cpl_valid && (int'(cpl_id) < NUM_REQ) && (m_pend[cpl_id] > 0);
            hs    = m_offer && gnt_ready;
            if (hs) begin
               m_count++;
               m_pend[m_id]++;
               m_ptr   = (m_id + 1) % NUM_REQ;
               m_offer = 0;
            end else if (!m_offer && req != 0 &&
                         !(m_count == MAX_OUT && !legal)) begin
               id = 0;
               for (int k = 0; k < NUM_REQ; k++) begin
                  id = (m_ptr + k) % NUM_REQ;
                  if (req[id]) break;
               end
               m_offer = 1;
               m_id    = id;
               exp_q.push_back(id);
            end
            if (legal) begin
               m_count--;
               m_pend[cpl_id]--;
            end
            if (cpl_valid && !legal) m_err = 1;
         end
      end
   end

   // Monitor: compares DUT outputs with the model away from the clock edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rstn) begin
            chk("count", int'(count), m_count);
            chk("full", int'(full), int'(m_count == MAX_OUT));
            chk("empty", int'(empty), int'(m_count == 0));
            chk("cpl_err", int'(cpl_err), int'(m_err));
            if (gnt_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_grant", int'(gnt_valid), 0);
               end else begin
                  chk("gnt_id", int'(gnt_id), exp_q[0]);
                  chk("gnt_onehot", int'(gnt), 1 << exp_q[0]);
                  if (gnt_ready) void'(exp_q.pop_front());
               end
            end else begin
               chk("missing_offer", exp_q.size(), 0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pick_legal_cpl();
      int off;
      int id;
      off = $urandom % NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
         id = (off + k) % NUM_REQ;
         if (m_pend[id] > 0) begin
            cpl_valid = 1'b1;
            cpl_id    = ID_W'(id);
            break;
         end
      end
   endtask

   initial begin
      bit found;

      // reset state, before any clock edge
      #3;
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_gnt_id", int'(gnt_id), 0);
      chk("rst_gnt_valid", int'(gnt_valid), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_cpl_err", int'(cpl_err), 0);
      cyc(2);
      rstn = 1'b1;
      cyc(1);

      // fairness: all requesting, grants 0,1,2,3 every other cycle
      req       = 4'b1111;
      gnt_ready = 1'b1;
      for (int g = 0; g < NUM_REQ; g++) begin
         cyc(g == 0 ? 1 : 2);
         chk("rr_valid", int'(gnt_valid), 1);
         chk("rr_id", int'(gnt_id), g);
      end
      cyc(3);
      chk("rr_count", int'(count), 4);
      chk("rr_full", int'(full), 1);
      chk("rr_idle_when_full", int'(gnt_valid), 0);

      // full pool with a same-cycle legal completion
      req       = 4'b0001;
      cpl_valid = 1'b1;
      cpl_id    = 2'd3;
      cyc(1);
      cpl_valid = 1'b0;
      req       = 4'b0000;
      chk("fullcpl_valid", int'(gnt_valid), 1);
      chk("fullcpl_id", int'(gnt_id), 0);
      chk("fullcpl_count_mid", int'(count), 3);
      cyc(1);
      chk("fullcpl_count", int'(count), 4);
      chk("fullcpl_pend3", m_pend[3], 0);

      // randomized traffic with legal completions
      for (int i = 0; i < 1500; i++) begin
         req       = NUM_REQ'($urandom);
         gnt_ready = ($urandom % 4) != 0;
         cpl_valid = 1'b0;
         if ($urandom % (i < 750 ? 5 : 2) == 0) pick_legal_cpl();
         cyc(1);
      end

      // drain the pool
      req       = '0;
      cpl_valid = 1'b0;
      gnt_ready = 1'b1;
      cyc(3);
      for (int i = 0; i < 40 && m_count > 0; i++) begin
         cpl_valid = 1'b0;
         pick_legal_cpl();
         cyc(1);
      end
      cpl_valid = 1'b0;
      cyc(1);
      chk("drain_count", int'(count), 0);
      chk("drain_empty", int'(empty), 1);

      // backpressure: offer stays committed while req drops
      req       = 4'b0100;
      gnt_ready = 1'b0;
      cyc(1);
      for (int c = 0; c < 6; c++) begin
         if (c == 1) req = 4'b0000;
         if (c == 5) gnt_ready = 1'b1;
         chk("bp_valid", int'(gnt_valid), 1);
         chk("bp_gnt", int'(gnt), 4);
         chk("bp_id", int'(gnt_id), 2);
         chk("bp_count", int'(count), 0);
         cyc(1);
      end
      chk("bp_count_after", int'(count), 1);
      chk("bp_valid_after", int'(gnt_valid), 0);

      // retire it, then an illegal completion
      cpl_valid = 1'b1;
      cpl_id    = 2'd2;
      cyc(1);
      cpl_valid = 1'b0;
      cyc(1);
      chk("ill_pre_count", int'(count), 0);
      chk("ill_pre_err", int'(cpl_err), 0);
      cpl_valid = 1'b1;
      cpl_id    = 2'd2;
      cyc(1);
      cpl_valid = 1'b0;
      cyc(3);
      chk("ill_count", int'(count), 0);
      chk("ill_empty", int'(empty), 1);
      chk("ill_err_sticky", int'(cpl_err), 1);

      // asynchronous reset mid-offer at count 3
      req       = 4'b1111;
      gnt_ready = 1'b1;
      found     = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cyc(1);
         if (m_count == 3 && m_offer) begin
            gnt_ready = 1'b0;
            found     = 1'b1;
         end
      end
      chk("arst_pre_valid", int'(gnt_valid), 1);
      chk("arst_pre_count", int'(count), 3);
      cyc(1);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_valid", int'(gnt_valid), 0);
      chk("arst_gnt", int'(gnt), 0);
      chk("arst_gnt_id", int'(gnt_id), 0);
      chk("arst_count", int'(count), 0);
      chk("arst_full", int'(full), 0);
      chk("arst_empty", int'(empty), 1);
      chk("arst_err", int'(cpl_err), 0);
      cyc(2);
      rstn      = 1'b1;
      req       = 4'b1010;
      gnt_ready = 1'b1;
      cyc(1);
      chk("arst_first_valid", int'(gnt_valid), 1);
      chk("arst_first_id", int'(gnt_id), 1);
      cyc(2);
      chk("arst_first_count", int'(count), 1);

      req = '0;
      cyc(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
